// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, instruction-memory request/ack fetch and IR for the control unit
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 TIMEOUT  = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              W_PC,
  input  logic              S_MXPC,
  input  logic [ADDR_W-1:0] PC_TARGET,
  output logic              IM_REQ,
  output logic [ADDR_W-1:0] IM_ADDR,
  input  logic              IM_ACK,
  input  logic [31:0]       IM_DATA,
  output logic [31:0]       IR,
  output logic [2:0]        TYPE,
  output logic [4:0]        OP,
  output logic              INSTR_VALID,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic [ADDR_W-1:0] PC_INC,
  output logic [31:0]       INSTR_CNT,
  output logic              IM_ERR
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // Counter only has to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
  localparam int                TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]     TMO_ONE  = TW'(1);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [31:0]       ir_q;
  logic              valid_q;
  logic [31:0]       cnt_q;
  logic              err_q;
  logic [TW-1:0]     tmo_q;

  assign pc_d = S_MXPC ? PC_TARGET : (pc_q + PC_ONE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          // An ACK on the final wait cycle still wins over the timeout.
          if (IM_ACK) begin
            ir_q    <= IM_DATA;
            valid_q <= 1'b1;
            tmo_q   <= '0;
            state_q <= S_HOLD;
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_ONE;
          end
        end
        S_HOLD: begin
          if (W_PC) begin
            pc_q    <= pc_d;
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + 32'd1;
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign IM_REQ      = (state_q == S_FETCH);
  assign IM_ADDR     = pc_q;
  assign PC_OUT      = pc_q;
  assign PC_INC      = pc_q + PC_ONE;
  assign IR          = ir_q;
  assign TYPE        = ir_q[31:29];
  assign OP          = ir_q[28:24];
  assign INSTR_VALID = valid_q;
  assign INSTR_CNT   = cnt_q;
  assign IM_ERR      = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - table-driven bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        w_pc;
  logic        s_mxpc;
  logic [15:0] pc_target;
  logic        im_req;
  logic [15:0] im_addr;
  logic        im_ack;
  logic [31:0] im_data;
  logic [31:0] ir;
  logic [2:0]  typ;
  logic [4:0]  op;
  logic        instr_valid;
  logic [15:0] pc_out;
  logic [15:0] pc_inc;
  logic [31:0] instr_cnt;
  logic        im_err;

  instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .TIMEOUT(15)) dut (
    .CLK(clk), .RESET(rst), .W_PC(w_pc), .S_MXPC(s_mxpc), .PC_TARGET(pc_target),
    .IM_REQ(im_req), .IM_ADDR(im_addr), .IM_ACK(im_ack), .IM_DATA(im_data),
    .IR(ir), .TYPE(typ), .OP(op), .INSTR_VALID(instr_valid),
    .PC_OUT(pc_out), .PC_INC(pc_inc), .INSTR_CNT(instr_cnt), .IM_ERR(im_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic        s;
    logic [15:0] tgt;
    logic        ack;
    logic [31:0] data;
    logic        e_req;
    logic [15:0] e_pc;
    logic        e_valid;
    logic [31:0] e_ir;
    logic [31:0] e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  task automatic add(input logic w, input logic s, input logic [15:0] tgt,
                     input logic ack, input logic [31:0] data,
                     input logic e_req, input logic [15:0] e_pc, input logic e_valid,
                     input logic [31:0] e_ir, input logic [31:0] e_cnt, input logic e_err);
    vec_t v;
    v.w = w; v.s = s; v.tgt = tgt; v.ack = ack; v.data = data;
    v.e_req = e_req; v.e_pc = e_pc; v.e_valid = e_valid;
    v.e_ir = e_ir; v.e_cnt = e_cnt; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    vec_t        v;
    logic [15:0] inc;
    checks = 0;
    failures = 0;
    rst = 1'b1; w_pc = 0; s_mxpc = 0; pc_target = '0; im_ack = 0; im_data = '0;

    // Sequential fetch with same-cycle ACK, retire after 3 valid cycles
    add(0,0,16'h0000,0,32'h0,        0,16'h0000,0,32'h0,        0,0);
    add(0,0,16'h0000,1,32'h2A000000, 1,16'h0000,0,32'h0,        0,0);
    add(0,0,16'h0000,0,32'h0,        0,16'h0000,1,32'h2A000000, 0,0);
    add(0,0,16'h0000,0,32'h0,        0,16'h0000,1,32'h2A000000, 0,0);
    add(1,0,16'h0000,0,32'h0,        0,16'h0000,1,32'h2A000000, 0,0);
    add(0,0,16'h0000,1,32'h20000001, 1,16'h0001,0,32'h2A000000, 1,0);
    // Jump to 5, W_PC during FETCH ignored, branch from 5 to 0x0100
    add(1,1,16'h0005,0,32'h0,        0,16'h0001,1,32'h20000001, 1,0);
    add(1,0,16'h0000,0,32'h0,        1,16'h0005,0,32'h20000001, 2,0);
    add(0,0,16'h0000,1,32'h45000005, 1,16'h0005,0,32'h20000001, 2,0);
    add(1,1,16'h0100,0,32'h0,        0,16'h0005,1,32'h45000005, 2,0);
    // ACK after 3 wait cycles
    for (int i = 0; i < 3; i++)
      add(0,0,16'h0000,0,32'h0,      1,16'h0100,0,32'h45000005, 3,0);
    add(0,0,16'h0000,1,32'hE0000100, 1,16'h0100,0,32'h45000005, 3,0);
    // Jump to 0xFFFF, then sequential wrap to 0
    add(1,1,16'hFFFF,0,32'h0,        0,16'h0100,1,32'hE0000100, 3,0);
    add(0,0,16'h0000,1,32'h1F00FFFF, 1,16'hFFFF,0,32'hE0000100, 4,0);
    add(1,0,16'h0000,0,32'h0,        0,16'hFFFF,1,32'h1F00FFFF, 4,0);
    // ACK on the 15th request cycle: latched, no error
    for (int i = 0; i < 14; i++)
      add(0,0,16'h0000,0,32'h0,      1,16'h0000,0,32'h1F00FFFF, 5,0);
    add(0,0,16'h0000,1,32'h6B000000, 1,16'h0000,0,32'h1F00FFFF, 5,0);
    add(1,0,16'h0000,0,32'h0,        0,16'h0000,1,32'h6B000000, 5,0);
    // No ACK for 15 cycles: one IDLE cycle, error set, retry same PC (W_PC in IDLE ignored)
    for (int i = 0; i < 15; i++)
      add(0,0,16'h0000,0,32'h0,      1,16'h0001,0,32'h6B000000, 6,0);
    add(1,0,16'h0000,0,32'h0,        0,16'h0001,0,32'h6B000000, 6,1);
    add(0,0,16'h0000,1,32'h8C000001, 1,16'h0001,0,32'h6B000000, 6,1);
    add(0,0,16'h0000,0,32'h0,        0,16'h0001,1,32'h8C000001, 6,1);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      inc = v.e_pc + 16'd1;
      #1;
      chk($sformatf("v%0d im_req", i),      32'(im_req),      32'(v.e_req));
      chk($sformatf("v%0d im_addr", i),     32'(im_addr),     32'(v.e_pc));
      chk($sformatf("v%0d pc_out", i),      32'(pc_out),      32'(v.e_pc));
      chk($sformatf("v%0d pc_inc", i),      32'(pc_inc),      32'(inc));
      chk($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(v.e_valid));
      chk($sformatf("v%0d ir", i),          ir,               v.e_ir);
      chk($sformatf("v%0d type", i),        32'(typ),         32'(v.e_ir[31:29]));
      chk($sformatf("v%0d op", i),          32'(op),          32'(v.e_ir[28:24]));
      chk($sformatf("v%0d instr_cnt", i),   instr_cnt,        v.e_cnt);
      chk($sformatf("v%0d im_err", i),      32'(im_err),      32'(v.e_err));
      w_pc = v.w; s_mxpc = v.s; pc_target = v.tgt; im_ack = v.ack; im_data = v.data;
      @(negedge clk);
    end
    w_pc = 0; s_mxpc = 0; pc_target = '0; im_ack = 0; im_data = '0;

    // Hand-decoded TYPE/OP of 0x2A000000 already passed; now async reset from HOLD
    #3 rst = 1'b1;
    #1;
    chk("async_rst im_req",      32'(im_req),      32'h0);
    chk("async_rst pc_out",      32'(pc_out),      32'h0);
    chk("async_rst pc_inc",      32'(pc_inc),      32'h1);
    chk("async_rst ir",          ir,               32'h0);
    chk("async_rst instr_valid", 32'(instr_valid), 32'h0);
    chk("async_rst instr_cnt",   instr_cnt,        32'h0);
    chk("async_rst im_err",      32'(im_err),      32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("post_rst idle im_req", 32'(im_req), 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst fetch im_req",  32'(im_req),  32'h1);
    chk("post_rst fetch im_addr", 32'(im_addr), 32'h0);

    // Reset mid-FETCH, stale ACK in the cycle after release
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    im_ack = 1'b1; im_data = 32'hDEADBEEF;
    @(posedge clk);
    #1 im_ack = 1'b0; im_data = '0;
    chk("stale_ack ir",          ir,               32'h0);
    chk("stale_ack instr_valid", 32'(instr_valid), 32'h0);
    chk("stale_ack im_req",      32'(im_req),      32'h1);
    @(posedge clk);
    #1;
    chk("stale_ack later ir",     ir,               32'h0);
    chk("stale_ack later valid",  32'(instr_valid), 32'h0);
    chk("stale_ack later im_err", 32'(im_err),      32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
